// File: rtl/ram_pkg.sv
// Shared types and helpers for the two-read/one-write unified RAM.
// Address decode, range check and byte-merge operate on fixed maximum widths;
// callers zero-extend their operands and truncate the result.
package ram_pkg;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;
    localparam int          MAX_DATA_W        = 1024;
    localparam int          MAX_BYTES         = MAX_DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Word index of a byte address relative to the array base.
    function automatic logic [63:0] index_of(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned shift);
        return (addr - base) >> shift;
    endfunction

    // True when base <= addr < base + span; written without forming base + span
    // so a base near the top of the address space cannot overflow.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

    // Replace the bytes of old_word whose mask bit is set with those of wdata.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(input logic [MAX_DATA_W-1:0] old_word,
                                                          input logic [MAX_DATA_W-1:0] wdata,
                                                          input logic [MAX_BYTES-1:0]  wmask);
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (wmask[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset zero-fill sequencer: walks indices 0..DEPTH-1, one word per cycle.
// Provides a write port (wen/idx/wdata) that takes priority over dmem stores.
// busy is registered and drops on the edge that writes the last index.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int DEPTH          = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int IDX_W         = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    output logic              clr_wen,
    output logic [IDX_W-1:0]  clr_idx,
    output logic [DATA_W-1:0] clr_wdata
);

    state_t state;

    assign clr_wen   = (state == CLEAR);
    assign clr_wdata = '0;

    // Clear FSM: reset restarts the walk at index 0, READY is terminal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= CLEAR_ON_RESET ? CLEAR : READY;
            busy    <= CLEAR_ON_RESET;
            clr_idx <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_idx == IDX_W'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram2r1w_bytemask.sv
// Unified 2-read/1-write RAM: imem 32-bit lane reads, dmem byte-masked word access.
// Reads return one cycle after the sampling edge; dmem store to imem read is write-first.
// No back-pressure; all requests are dropped while the post-reset clear runs.
module ram2r1w_bytemask
    import ram_pkg::*;
#(
    parameter int          DATA_W         = 64,
    parameter int          ADDR_W         = 64,
    parameter int          DEPTH          = 65536,
    parameter logic [63:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_imem_en,
    input  logic [ADDR_W-1:0]     io_imem_addr,
    output logic [31:0]           io_imem_rdata,
    output logic                  io_imem_valid,
    input  logic                  io_dmem_en,
    input  logic [ADDR_W-1:0]     io_dmem_addr,
    input  logic                  io_dmem_wen,
    input  logic [DATA_W-1:0]     io_dmem_wdata,
    input  logic [DATA_W/8-1:0]   io_dmem_wmask,
    output logic [DATA_W-1:0]     io_dmem_rdata,
    output logic                  io_dmem_valid,
    output logic                  io_err,
    output logic                  io_busy
);

    localparam int          BYTES  = DATA_W / 8;
    localparam int          OFF_W  = $clog2(BYTES);
    localparam int          IDX_W  = $clog2(DEPTH);
    localparam int          LANE_W = OFF_W - 2;
    localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(BYTES);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_wen;
    logic [IDX_W-1:0]  clr_idx;
    logic [DATA_W-1:0] clr_wdata;

    logic [63:0]       i_addr64;
    logic [63:0]       d_addr64;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  d_idx;
    logic              i_in;
    logic              d_in;
    logic              i_req;
    logic              d_req;
    logic              d_rd;
    logic              d_wr;
    logic [LANE_W-1:0] i_lane;
    logic [DATA_W-1:0] d_old;
    logic [DATA_W-1:0] d_merged;
    logic [DATA_W-1:0] i_word;
    logic [31:0]       i_lane_dat;

    ram_clear_seq #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clock     (clock),
        .reset     (reset),
        .busy      (io_busy),
        .clr_wen   (clr_wen),
        .clr_idx   (clr_idx),
        .clr_wdata (clr_wdata)
    );

    assign i_addr64 = 64'(io_imem_addr);
    assign d_addr64 = 64'(io_dmem_addr);
    assign i_idx    = IDX_W'(index_of(i_addr64, BASE_ADDR, OFF_W));
    assign d_idx    = IDX_W'(index_of(d_addr64, BASE_ADDR, OFF_W));
    assign i_in     = in_range(i_addr64, BASE_ADDR, SPAN);
    assign d_in     = in_range(d_addr64, BASE_ADDR, SPAN);
    assign i_lane   = io_imem_addr[OFF_W-1:2];

    // Requests are only honoured once the clear has finished.
    assign i_req = io_imem_en && !io_busy;
    assign d_req = io_dmem_en && !io_busy;
    assign d_rd  = d_req && !io_dmem_wen;
    assign d_wr  = d_req && io_dmem_wen && d_in;

    assign d_old    = mem[d_idx];
    assign d_merged = DATA_W'(merge_bytes(MAX_DATA_W'(d_old),
                                          MAX_DATA_W'(io_dmem_wdata),
                                          MAX_BYTES'(io_dmem_wmask)));

    // Write-first forwarding: an imem read of the word being stored sees the merged value.
    assign i_word     = (d_wr && (d_idx == i_idx)) ? d_merged : mem[i_idx];
    assign i_lane_dat = i_word[{i_lane, 5'b0} +: 32];

    // Array write port: clear sequencer has priority over dmem stores.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clr_wen) begin
                mem[clr_idx] <= clr_wdata;
            end else if (d_wr) begin
                mem[d_idx] <= d_merged;
            end
        end
    end

    // Registered read data, one-cycle valid strobes and error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_imem_rdata <= '0;
            io_imem_valid <= 1'b0;
            io_dmem_rdata <= '0;
            io_dmem_valid <= 1'b0;
            io_err        <= 1'b0;
        end else begin
            io_imem_valid <= i_req;
            io_dmem_valid <= d_rd;
            io_err        <= (i_req && !i_in) || (d_req && !d_in);
            if (i_req) begin
                io_imem_rdata <= i_in ? i_lane_dat : 32'h0;
            end
            if (d_rd) begin
                io_dmem_rdata <= d_in ? d_old : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram2r1w_bytemask.sv
// Directed bench for ram2r1w_bytemask with DEPTH=16, DATA_W=64, BASE_ADDR=0x8000_0000.
// A vector table covers per-cycle behaviour; hand sequences cover clear and reset.
module tb_ram2r1w_bytemask;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_imem_en = 1'b0;
    logic [63:0] io_imem_addr = '0;
    logic [31:0] io_imem_rdata;
    logic        io_imem_valid;
    logic        io_dmem_en = 1'b0;
    logic [63:0] io_dmem_addr = '0;
    logic        io_dmem_wen = 1'b0;
    logic [63:0] io_dmem_wdata = '0;
    logic [7:0]  io_dmem_wmask = '0;
    logic [63:0] io_dmem_rdata;
    logic        io_dmem_valid;
    logic        io_err;
    logic        io_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram2r1w_bytemask #(
        .DATA_W         (64),
        .ADDR_W         (64),
        .DEPTH          (16),
        .BASE_ADDR      (64'h8000_0000),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_imem_en    (io_imem_en),
        .io_imem_addr  (io_imem_addr),
        .io_imem_rdata (io_imem_rdata),
        .io_imem_valid (io_imem_valid),
        .io_dmem_en    (io_dmem_en),
        .io_dmem_addr  (io_dmem_addr),
        .io_dmem_wen   (io_dmem_wen),
        .io_dmem_wdata (io_dmem_wdata),
        .io_dmem_wmask (io_dmem_wmask),
        .io_dmem_rdata (io_dmem_rdata),
        .io_dmem_valid (io_dmem_valid),
        .io_err        (io_err),
        .io_busy       (io_busy)
    );

    typedef struct {
        logic        d_en;
        logic        d_wen;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_mask;
        logic        i_en;
        logic [63:0] i_addr;
        logic        e_dv;
        logic [63:0] e_dd;
        logic        e_iv;
        logic [31:0] e_id;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic d_en, input logic d_wen, input logic [63:0] d_addr,
                       input logic [63:0] d_wdata, input logic [7:0] d_mask,
                       input logic i_en, input logic [63:0] i_addr,
                       input logic e_dv, input logic [63:0] e_dd,
                       input logic e_iv, input logic [31:0] e_id, input logic e_err);
        vec_t v;
        v.d_en = d_en; v.d_wen = d_wen; v.d_addr = d_addr; v.d_wdata = d_wdata;
        v.d_mask = d_mask; v.i_en = i_en; v.i_addr = i_addr;
        v.e_dv = e_dv; v.e_dd = e_dd; v.e_iv = e_iv; v.e_id = e_id; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic idle();
        io_imem_en    = 1'b0;
        io_imem_addr  = '0;
        io_dmem_en    = 1'b0;
        io_dmem_wen   = 1'b0;
        io_dmem_addr  = '0;
        io_dmem_wdata = '0;
        io_dmem_wmask = '0;
    endtask

    // Counts negedges with busy high; returns with the bench sitting on a negedge.
    task automatic count_busy(output int cnt, output bit saw_valid);
        int guard;
        cnt = 0;
        guard = 0;
        saw_valid = 1'b0;
        @(negedge clock);
        while (io_busy && guard < 40) begin
            cnt++;
            guard++;
            if (io_dmem_valid || io_imem_valid) saw_valid = 1'b1;
            @(negedge clock);
        end
    endtask

    initial begin
        int  cnt;
        bit  saw;

        // dmem: en wen addr wdata mask | imem: en addr | expect: dv dd iv id err
        add(1,0,64'h8000_0078,64'h0,8'h00, 0,64'h0, 1,64'h0,                0,32'h0,        0);
        add(0,0,64'h0,        64'h0,8'h00, 0,64'h0, 0,64'h0,                0,32'h0,        0);
        add(1,1,64'h8000_0008,64'h1122334455667788,8'hFF, 0,64'h0, 0,64'h0, 0,32'h0,        0);
        add(1,1,64'h8000_0008,64'hAAAAAAAAAAAAAAAA,8'h0F, 0,64'h0, 0,64'h0, 0,32'h0,        0);
        add(1,0,64'h8000_0008,64'h0,8'h00, 0,64'h0, 1,64'h11223344AAAAAAAA, 0,32'h0,        0);
        add(1,1,64'h8000_0010,64'hDEADBEEFCAFEF00D,8'hFF, 1,64'h8000_0014,
                                                    0,64'h11223344AAAAAAAA, 1,32'hDEADBEEF, 0);
        add(0,0,64'h0,        64'h0,8'h00, 1,64'h8000_0010, 0,64'h11223344AAAAAAAA, 1,32'hCAFEF00D, 0);
        add(1,0,64'h8000_0080,64'h0,8'h00, 0,64'h0, 1,64'h0,                0,32'hCAFEF00D, 1);
        add(0,0,64'h0,        64'h0,8'h00, 0,64'h0, 0,64'h0,                0,32'hCAFEF00D, 0);
        add(1,1,64'h7FFF_FFF8,64'hFFFFFFFFFFFFFFFF,8'hFF, 0,64'h0, 0,64'h0, 0,32'hCAFEF00D, 1);
        add(1,0,64'h8000_0078,64'h0,8'h00, 0,64'h0, 1,64'h0,                0,32'hCAFEF00D, 0);
        add(1,1,64'h8000_0008,64'h0,8'h00, 0,64'h0, 0,64'h0,                0,32'hCAFEF00D, 0);
        add(1,0,64'h8000_0008,64'h0,8'h00, 0,64'h0, 1,64'h11223344AAAAAAAA, 0,32'hCAFEF00D, 0);
        add(1,1,64'h8000_0000,64'h0000000200000001,8'hFF, 0,64'h0, 0,64'h11223344AAAAAAAA, 0,32'hCAFEF00D, 0);
        add(1,0,64'h8000_0010,64'h0,8'h00, 1,64'h8000_0000, 1,64'hDEADBEEFCAFEF00D, 1,32'h00000001, 0);
        add(0,0,64'h0,        64'h0,8'h00, 1,64'h8000_0004, 0,64'hDEADBEEFCAFEF00D, 1,32'h00000002, 0);
        add(0,0,64'h0,        64'h0,8'h00, 1,64'h8000_0008, 0,64'hDEADBEEFCAFEF00D, 1,32'hAAAAAAAA, 0);
        add(0,0,64'h0,        64'h0,8'h00, 1,64'h8000_000C, 0,64'hDEADBEEFCAFEF00D, 1,32'h11223344, 0);
        add(0,0,64'h0,        64'h0,8'h00, 0,64'h0,         0,64'hDEADBEEFCAFEF00D, 0,32'h11223344, 0);
        add(0,0,64'h0,        64'h0,8'h00, 1,64'h8000_0080, 0,64'hDEADBEEFCAFEF00D, 1,32'h0,        1);
        add(0,0,64'h0,        64'h0,8'h00, 0,64'h0,         0,64'hDEADBEEFCAFEF00D, 0,32'h0,        0);
        add(1,1,64'h8000_0010,64'h0000000000550000,8'h04, 0,64'h0, 0,64'hDEADBEEFCAFEF00D, 0,32'h0, 0);
        add(1,0,64'h8000_0010,64'h0,8'h00, 0,64'h0, 1,64'hDEADBEEFCA55F00D, 0,32'h0,        0);
        add(1,1,64'h8000_0060,64'h5A5A5A5A5A5A5A5A,8'hFF, 0,64'h0, 0,64'hDEADBEEFCA55F00D, 0,32'h0, 0);
        add(1,0,64'h8000_0060,64'h0,8'h00, 0,64'h0, 1,64'h5A5A5A5A5A5A5A5A, 0,32'h0,        0);

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst imem_rdata", 64'(io_imem_rdata), 64'h0);
        chk("rst dmem_rdata", io_dmem_rdata, 64'h0);
        chk("rst imem_valid", 64'(io_imem_valid), 64'h0);
        chk("rst dmem_valid", 64'(io_dmem_valid), 64'h0);
        chk("rst err", 64'(io_err), 64'h0);
        chk("rst busy", 64'(io_busy), 64'h1);

        // Clear after reset, with a read held on dmem that must be ignored
        @(posedge clock);
        #1;
        reset        = 1'b0;
        io_dmem_en   = 1'b1;
        io_dmem_addr = 64'h8000_0000;
        count_busy(cnt, saw);
        chk("clear busy cycles", 64'(cnt), 64'd16);
        chk("no valid while busy", 64'(saw), 64'h0);

        // Table-driven vectors
        for (int k = 0; k < vecs.size(); k++) begin
            io_dmem_en    = vecs[k].d_en;
            io_dmem_wen   = vecs[k].d_wen;
            io_dmem_addr  = vecs[k].d_addr;
            io_dmem_wdata = vecs[k].d_wdata;
            io_dmem_wmask = vecs[k].d_mask;
            io_imem_en    = vecs[k].i_en;
            io_imem_addr  = vecs[k].i_addr;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d dmem_valid", k), 64'(io_dmem_valid), 64'(vecs[k].e_dv));
            chk($sformatf("v%0d dmem_rdata", k), io_dmem_rdata, vecs[k].e_dd);
            chk($sformatf("v%0d imem_valid", k), 64'(io_imem_valid), 64'(vecs[k].e_iv));
            chk($sformatf("v%0d imem_rdata", k), 64'(io_imem_rdata), 64'(vecs[k].e_id));
            chk($sformatf("v%0d err", k), 64'(io_err), 64'(vecs[k].e_err));
        end

        // In-flight read strobe is squashed by reset
        io_dmem_en    = 1'b1;
        io_dmem_wen   = 1'b0;
        io_dmem_addr  = 64'h8000_0010;
        io_imem_en    = 1'b0;
        @(posedge clock);
        #1;
        chk("pre-rst dmem_valid", 64'(io_dmem_valid), 64'h1);
        chk("pre-rst dmem_rdata", io_dmem_rdata, 64'hDEADBEEFCA55F00D);
        idle();
        reset = 1'b1;
        #1;
        chk("squash dmem_valid", 64'(io_dmem_valid), 64'h0);
        chk("squash dmem_rdata", io_dmem_rdata, 64'h0);
        chk("squash busy", 64'(io_busy), 64'h1);

        // Start a clear, then reset it at cycle 7 for two cycles
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midclr busy r1", 64'(io_busy), 64'h1);
        @(negedge clock);
        chk("midclr busy r2", 64'(io_busy), 64'h1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        count_busy(cnt, saw);
        chk("restart busy cycles", 64'(cnt), 64'd16);

        // Contents written before the reset are gone
        io_dmem_en   = 1'b1;
        io_dmem_wen  = 1'b0;
        io_dmem_addr = 64'h8000_0060;
        @(posedge clock);
        #1;
        chk("post-clr dmem_valid", 64'(io_dmem_valid), 64'h1);
        chk("post-clr dmem_rdata", io_dmem_rdata, 64'h0);
        io_dmem_addr = 64'h8000_0010;
        @(posedge clock);
        #1;
        chk("post-clr rd10 rdata", io_dmem_rdata, 64'h0);
        idle();
        @(posedge clock);
        #1;
        chk("post-clr valid drop", 64'(io_dmem_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
